// File: rtl/hilo_mult_ctrl.sv
// HI/LO register owner and operand sequencer for the multi-cycle combinational multiplier.
// Holds operands stable for MULT_LATENCY cycles, commits the 64-bit product, and interlocks HI/LO access.
module hilo_mult_ctrl #(
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_is_unsigned,
  input  logic [31:0] i_opr1,
  input  logic [31:0] i_opr2,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_wdata,
  input  logic        i_mfhi,
  input  logic        i_mflo,
  input  logic        i_flush,
  output logic [31:0] o_mult_opr1,
  output logic [31:0] o_mult_opr2,
  output logic        o_mult_unsigned,
  input  logic [31:0] i_mult_hi,
  input  logic [31:0] i_mult_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opr1_q, opr1_d;
  logic [31:0]      opr2_q, opr2_d;
  logic             uns_q, uns_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opr1_d  = opr1_q;
    opr2_d  = opr2_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!i_flush) begin
          // MT writes land now; a same-cycle start overwrites both at completion.
          if (i_mthi) hi_d = i_wdata;
          if (i_mtlo) lo_d = i_wdata;
          if (i_start) begin
            opr1_d  = i_opr1;
            opr2_d  = i_opr2;
            uns_d   = i_is_unsigned;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (i_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = i_mult_hi;
          lo_d    = i_mult_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opr1_q  <= '0;
      opr2_q  <= '0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr1_q  <= opr1_d;
      opr2_q  <= opr2_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign o_busy          = (state_q == CALC);
  assign o_stall         = o_busy & (i_start | i_mthi | i_mtlo | i_mfhi | i_mflo);
  assign o_mult_opr1     = opr1_q;
  assign o_mult_opr2     = opr2_q;
  assign o_mult_unsigned = uns_q;
  assign o_hi            = hi_q;
  assign o_lo            = lo_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed self-checking bench for hilo_mult_ctrl; a behavioural multiplier feeds each instance.
module tb_hilo_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_is_unsigned, i_mthi, i_mtlo, i_mfhi, i_mflo, i_flush;
  logic [31:0] i_opr1, i_opr2, i_wdata;

  logic [31:0] m1_opr1, m1_opr2, m1_hi, m1_lo, hi1, lo1;
  logic        m1_uns, busy1, stall1, done1;
  logic [31:0] m2_opr1, m2_opr2, m2_hi, m2_lo, hi2, lo2;
  logic        m2_uns, busy2, stall2, done2;

  int unsigned tests = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic uns);
    logic signed [63:0] sa, sb;
    if (uns) return {32'b0, a} * {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  always_comb {m1_hi, m1_lo} = mul_model(m1_opr1, m1_opr2, m1_uns);
  always_comb {m2_hi, m2_lo} = mul_model(m2_opr1, m2_opr2, m2_uns);

  hilo_mult_ctrl #(.MULT_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_is_unsigned(i_is_unsigned),
    .i_opr1(i_opr1), .i_opr2(i_opr2), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
    .i_wdata(i_wdata), .i_mfhi(i_mfhi), .i_mflo(i_mflo), .i_flush(i_flush),
    .o_mult_opr1(m1_opr1), .o_mult_opr2(m1_opr2), .o_mult_unsigned(m1_uns),
    .i_mult_hi(m1_hi), .i_mult_lo(m1_lo), .o_hi(hi1), .o_lo(lo1),
    .o_busy(busy1), .o_stall(stall1), .o_done(done1)
  );

  hilo_mult_ctrl #(.MULT_LATENCY(1), .CNT_W(4)) dut_lat1 (
    .clk(clk), .reset(reset), .i_start(i_start), .i_is_unsigned(i_is_unsigned),
    .i_opr1(i_opr1), .i_opr2(i_opr2), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
    .i_wdata(i_wdata), .i_mfhi(i_mfhi), .i_mflo(i_mflo), .i_flush(i_flush),
    .o_mult_opr1(m2_opr1), .o_mult_opr2(m2_opr2), .o_mult_unsigned(m2_uns),
    .i_mult_hi(m2_hi), .i_mult_lo(m2_lo), .o_hi(hi2), .o_lo(lo2),
    .o_busy(busy2), .o_stall(stall2), .o_done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_start = 0; i_is_unsigned = 0; i_mthi = 0; i_mtlo = 0;
    i_mfhi = 0; i_mflo = 0; i_flush = 0; i_opr1 = '0; i_opr2 = '0; i_wdata = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_stall", 32'(stall1), 32'd0);
    chk("rst_hi", hi1, 32'h0);
    chk("rst_lo", lo1, 32'h0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_opr1", m1_opr1, 32'h0);
    chk("rst_uns", 32'(m1_uns), 32'd0);

    // MULTU 0xFFFFFFFF * 2
    i_start = 1; i_is_unsigned = 1; i_opr1 = 32'hFFFF_FFFF; i_opr2 = 32'h2;
    tick();
    i_start = 0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("multu_busy_c%0d", c), 32'(busy1), 32'd1);
      chk($sformatf("multu_done_c%0d", c), 32'(done1), 32'd0);
      tick();
    end
    chk("multu_busy_c5", 32'(busy1), 32'd0);
    chk("multu_done_c5", 32'(done1), 32'd1);
    chk("multu_hi", hi1, 32'h0000_0001);
    chk("multu_lo", lo1, 32'hFFFF_FFFE);
    tick();
    chk("multu_done_c6", 32'(done1), 32'd0);

    // Signed MULT -3 * 7, operand hold, and interlock
    i_start = 1; i_is_unsigned = 0; i_opr1 = 32'hFFFF_FFFD; i_opr2 = 32'h7;
    tick();
    i_start = 0; i_opr1 = 32'h0;
    chk("mult_opr1_hold_c1", m1_opr1, 32'hFFFF_FFFD);
    i_opr1 = 32'h0001_2345;
    i_mflo = 1;
    chk("mflo_stall", 32'(stall1), 32'd1);
    tick();
    chk("mult_opr1_hold_c2", m1_opr1, 32'hFFFF_FFFD);
    i_mflo = 0; i_mthi = 1; i_wdata = 32'h1234_5678;
    chk("mthi_stall_c2", 32'(stall1), 32'd1);
    tick();
    chk("mthi_hi_unchanged_c3", hi1, 32'h0000_0001);
    chk("mthi_stall_c3", 32'(stall1), 32'd1);
    tick();
    chk("mthi_stall_c4", 32'(stall1), 32'd1);
    chk("mthi_hi_unchanged_c4", hi1, 32'h0000_0001);
    tick();
    chk("mult_done", 32'(done1), 32'd1);
    chk("mult_busy_c5", 32'(busy1), 32'd0);
    chk("mult_stall_c5", 32'(stall1), 32'd0);
    chk("mult_hi", hi1, 32'hFFFF_FFFF);
    chk("mult_lo", lo1, 32'hFFFF_FFEB);
    tick();
    i_mthi = 0;
    chk("mthi_after_done_hi", hi1, 32'h1234_5678);
    chk("mthi_after_done_lo", lo1, 32'hFFFF_FFEB);
    chk("mthi_after_done_done", 32'(done1), 32'd0);

    // Flush mid-multiply retains prior HI/LO
    i_mthi = 1; i_wdata = 32'hAAAA_0000;
    tick();
    i_mthi = 0; i_mtlo = 1; i_wdata = 32'h0000_BBBB;
    tick();
    i_mtlo = 0;
    chk("pre_flush_hi", hi1, 32'hAAAA_0000);
    chk("pre_flush_lo", lo1, 32'h0000_BBBB);
    i_start = 1; i_opr1 = 32'd5; i_opr2 = 32'd6;
    tick();
    i_start = 0;
    tick();
    i_flush = 1;
    tick();
    i_flush = 0;
    chk("flush_busy", 32'(busy1), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("flush_no_done_%0d", c), 32'(done1), 32'd0);
      tick();
    end
    chk("flush_hi", hi1, 32'hAAAA_0000);
    chk("flush_lo", lo1, 32'h0000_BBBB);

    // Flush in IDLE suppresses start and MT writes
    i_flush = 1; i_start = 1; i_mthi = 1; i_mtlo = 1; i_wdata = 32'h1111_1111;
    tick();
    i_flush = 0; i_start = 0; i_mthi = 0; i_mtlo = 0;
    chk("idle_flush_busy", 32'(busy1), 32'd0);
    chk("idle_flush_hi", hi1, 32'hAAAA_0000);
    chk("idle_flush_lo", lo1, 32'h0000_BBBB);

    // Reset on the completion cycle wins over commit
    i_start = 1; i_opr1 = 32'd5; i_opr2 = 32'd6;
    tick();
    i_start = 0;
    tick(); tick(); tick();
    chk("rst_mid_busy_pre", 32'(busy1), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_hi", hi1, 32'h0);
    chk("rst_mid_lo", lo1, 32'h0);
    chk("rst_mid_done", 32'(done1), 32'd0);
    chk("rst_mid_opr1", m1_opr1, 32'h0);

    // Start + MTLO same cycle, both latencies
    i_mthi = 1; i_wdata = 32'hDEAD_0000;
    tick();
    i_mthi = 0;
    chk("smt_pre_hi", hi1, 32'hDEAD_0000);
    chk("smt_pre_hi_l1", hi2, 32'hDEAD_0000);
    i_mtlo = 1; i_wdata = 32'hCAFE_0000; i_start = 1; i_is_unsigned = 1;
    i_opr1 = 32'd2; i_opr2 = 32'd3;
    tick();
    i_mtlo = 0; i_start = 0;
    chk("smt_lo_c1", lo1, 32'hCAFE_0000);
    chk("smt_lo_c1_l1", lo2, 32'hCAFE_0000);
    chk("smt_busy_c1", 32'(busy1), 32'd1);
    chk("smt_busy_c1_l1", 32'(busy2), 32'd1);
    tick();
    chk("smt_busy_c2_l1", 32'(busy2), 32'd0);
    chk("smt_done_c2_l1", 32'(done2), 32'd1);
    chk("smt_lo_l1", lo2, 32'h0000_0006);
    chk("smt_hi_l1", hi2, 32'h0);
    chk("smt_busy_c2", 32'(busy1), 32'd1);
    tick();
    chk("smt_done_c3_l1", 32'(done2), 32'd0);
    tick(); tick();
    chk("smt_done_c5", 32'(done1), 32'd1);
    chk("smt_busy_c5", 32'(busy1), 32'd0);
    chk("smt_lo", lo1, 32'h0000_0006);
    chk("smt_hi", hi1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequencer and HI/LO register owner for the combinational 32x32 signed/unsigned multiplier in the CPU execute stage.
- Latches operands and drives them stable into the multiplier for a fixed number of cycles, which gives the multi-cycle path. It then commits the 64-bit product into HI/LO.
- Arbitrates MTHI/MTLO/MFHI/MFLO against an in-flight multiply and raises a pipeline stall on any conflict.

Parameters:
- MULT_LATENCY, 4, number of cycles operands are held before the product is captured. Legal range is 1..15.
- CNT_W, 4, width of the latency down-counter. Must satisfy 2^CNT_W > MULT_LATENCY.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_start  in  1  issue MULT/MULTU this cycle
- i_is_unsigned  in  1  1 = MULTU, 0 = MULT, sampled with i_start
- i_opr1  in  32  rs operand, sampled with i_start
- i_opr2  in  32  rt operand, sampled with i_start
- i_mthi  in  1  write i_wdata to HI
- i_mtlo  in  1  write i_wdata to LO
- i_wdata  in  32  MTHI/MTLO data
- i_mfhi  in  1  read of HI requested (interlock only)
- i_mflo  in  1  read of LO requested (interlock only)
- i_flush  in  1  pipeline flush/exception; aborts the in-flight multiply
- o_mult_opr1  out  32  latched operand 1 to multiplier
- o_mult_opr2  out  32  latched operand 2 to multiplier
- o_mult_unsigned  out  1  latched signedness to multiplier
- i_mult_hi  in  32  multiplier product [63:32]
- i_mult_lo  in  32  multiplier product [31:0]
- o_hi  out  32  HI register
- o_lo  out  32  LO register
- o_busy  out  1  multiply in flight
- o_stall  out  1  conflicting request while busy; stage must hold
- o_done  out  1  one-cycle pulse, the cycle after HI/LO commit

Behaviour:
- Reset, checked before every other term: state=IDLE, counter=0, o_hi=o_lo=0, operand latches=0, o_mult_unsigned=0, o_done=0. o_busy=0 and o_stall=0 follow combinationally.
- States are IDLE and CALC. o_busy = (state==CALC), combinational.
- IDLE & i_start & ~i_flush:
  - Latch i_opr1, i_opr2 and i_is_unsigned at the edge.
  - Move to CALC with counter=MULT_LATENCY-1.
- CALC & i_flush:
  - Go to IDLE at the edge; HI/LO are untouched and o_done stays 0.
  - i_flush has priority over completion.
- CALC & counter!=0: decrement the counter.
- CALC & counter==0 & ~i_flush:
  - Capture i_mult_hi into HI and i_mult_lo into LO at the edge.
  - Go to IDLE and set o_done=1 for the next cycle.
- Latency: with start in cycle 0, o_busy is high in cycles 1..MULT_LATENCY. New HI/LO are visible and o_done=1 in cycle MULT_LATENCY+1.
- Operand latches hold their value while in CALC, independent of the i_opr* inputs.
- o_stall = o_busy & (i_start | i_mthi | i_mtlo | i_mfhi | i_mflo), combinational.
  - While stalled, the request is ignored: no relatch and no HI/LO write.
  - The requester holds the request until o_stall drops.
- On the completion cycle o_busy is still 1, so requests that cycle stall. They are accepted the next cycle (IDLE).
- IDLE & i_mthi / i_mtlo:
  - Write i_wdata to HI / LO at the edge.
  - Both asserted writes both registers.
- IDLE & i_start together with i_mthi/i_mtlo in the same cycle:
  - The MT write happens now.
  - The product overwrites both registers at completion.
- IDLE & i_flush suppresses i_start and MT writes that cycle.
- i_mfhi/i_mflo have no state effect. o_hi/o_lo are always the registered values.
- Signedness and width arithmetic belong to the multiplier. This block passes all 64 product bits unmodified.

Test Plan:
- MULTU path: reset, then start with i_opr1=0xFFFFFFFF, i_opr2=0x00000002, unsigned=1.
  - o_busy is high for exactly 4 cycles.
  - In cycle 5: HI=0x00000001, LO=0xFFFFFFFE, o_done=1 for one cycle.
- Signed MULT: i_opr1=0xFFFFFFFD (-3), i_opr2=0x00000007.
  - After completion: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - o_mult_opr1 stays 0xFFFFFFFD while i_opr1 is toggled during CALC.
- Interlock: during CALC, assert i_mflo, then i_mthi with i_wdata=0x12345678.
  - o_stall=1 on both and HI is unchanged.
  - After o_done, a re-asserted MTHI succeeds: HI=0x12345678.
- Flush: start 5x6, then assert i_flush in the 2nd CALC cycle.
  - Returns to IDLE and o_done never fires.
  - Prior HI/LO (e.g. 0xAAAA0000/0x0000BBBB) are retained.
- Reset mid-operation: assert reset in CALC.
  - Next cycle o_busy=0, HI=LO=0, o_done=0.
- Simultaneous start+MTLO: in IDLE with i_wdata=0xCAFE0000, start 2x3.
  - LO=0xCAFE0000 on the next cycle.
  - LO=0x00000006 and HI=0 after completion.
  - Repeat with MULT_LATENCY=1: busy for 1 cycle only.
